// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, valid/ready on both sides, one op in flight.
module alu_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             spec_q, spec_d;
  logic [WIDTH-1:0] sres_q, sres_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Operand decode on the accept cycle
  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, min_int;
  logic             div_zero, div_ovf, is_spec;
  logic [WIDTH-1:0] spec_res;

  always_comb begin
    is_div   = op[2];
    a_sgn    = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_sgn    = is_div ? ~op[0] : (op[1:0] == 2'b01);
    a_neg    = a_sgn & a[WIDTH-1];
    b_neg    = b_sgn & b[WIDTH-1];
    a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
    min_int  = {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = is_div & (b == '0);
    div_ovf  = is_div & ~op[0] & (a == min_int) & (b == '1);
    is_spec  = div_zero | div_ovf;
    if (div_zero) begin
      spec_res = op[1] ? a : '1;
    end else begin
      spec_res = op[1] ? '0 : a;
    end
  end

  // One iteration of multiply or divide on the accumulator {hi, lo}
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = acc_q[AW-1:WIDTH-1];
    div_ge    = (div_trial >= {1'b0, bmag_q});
    div_diff  = div_trial[WIDTH-1:0] - bmag_q;
    div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    acc_step  = op_q[2] ? div_next : mul_next;
  end

  // Sign-corrected final result taken from the last iteration
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] div_val;
  logic [WIDTH-1:0] calc_res;

  always_comb begin
    prod    = neg_q ? (~acc_step + AW'(1)) : acc_step;
    div_val = op_q[1] ? acc_step[AW-1:WIDTH] : acc_step[WIDTH-1:0];
    if (op_q[2]) begin
      calc_res = neg_q ? (~div_val + WIDTH'(1)) : div_val;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod[WIDTH-1:0];
    end else begin
      calc_res = prod[AW-1:WIDTH];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    spec_d  = spec_q;
    sres_d  = sres_q;
    y_d     = y_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          neg_d  = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d  = {{WIDTH{1'b0}}, a_mag};
          bmag_d = b_mag;
          cnt_d  = CW'(WIDTH - 1);
          spec_d = is_spec;
          sres_d = spec_res;
          if (is_spec && EARLY_OUT) begin
            y_d     = spec_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          y_d     = spec_q ? sres_q : calc_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort keeps the previous result visible on y
    if (flush) begin
      state_d = S_IDLE;
      y_d     = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      bmag_q  <= '0;
      spec_q  <= 1'b0;
      sres_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      spec_q  <= spec_d;
      sres_q  <= sres_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;

endmodule
